// File: rtl/reindeer_csr_irq_if.sv
// CSR access bus between the pipeline (master) and the CSR unit (slave).
interface reindeer_csr_irq_if;
  logic        read_enable;
  logic [11:0] read_addr;
  logic        read_en_out;
  logic [31:0] read_data_out;
  logic        write_enable;
  logic [11:0] write_addr;
  logic [31:0] write_data_in;

  modport master (
    output read_enable, read_addr, write_enable, write_addr, write_data_in,
    input  read_en_out, read_data_out
  );

  modport slave (
    input  read_enable, read_addr, write_enable, write_addr, write_data_in,
    output read_en_out, read_data_out
  );
endinterface

// File: rtl/reindeer_csr_irq.sv
// Machine-mode CSR unit: counters, trap/mret stacking, local interrupt bank
// and registered interrupt request with fixed priority.
// Optional macro CSR_VECTORED_MTVEC_EN enables vectored mtvec mode.
module reindeer_csr_irq #(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter int          COUNTER_WIDTH = 64,
  parameter logic [31:0] HART_ID       = 32'h0,
  localparam int         LW = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic                   exe_enable,
  reindeer_csr_irq_if.slave      bus,
  input  logic                   timer_triggered,
  input  logic                   ext_int_triggered,
  input  logic [LW-1:0]          local_irq,
  input  logic                   csr_mret_active,
  input  logic                   activate_exception,
  input  logic                   is_interrupt,
  input  logic [4:0]             exception_code,
  input  logic [31:0]            exception_PC,
  input  logic [31:0]            exception_addr,
  output logic                   irq_req,
  output logic [4:0]             irq_code,
  output logic [31:0]            trap_target,
  output logic [31:0]            mepc_out,
  output logic                   illegal_csr
);
  localparam int CW = COUNTER_WIDTH;

  localparam logic [11:0] A_MSTATUS   = 12'h300, A_MISA     = 12'h301,
                          A_MIE       = 12'h304, A_MTVEC    = 12'h305,
                          A_MSCRATCH  = 12'h340, A_MEPC     = 12'h341,
                          A_MCAUSE    = 12'h342, A_MTVAL    = 12'h343,
                          A_MIP       = 12'h344, A_MCYCLE   = 12'hB00,
                          A_MINSTRET  = 12'hB02, A_MCYCLEH  = 12'hB80,
                          A_MINSTRETH = 12'hB82, A_MVENDOR  = 12'hF11,
                          A_MARCHID   = 12'hF12, A_MIMPID   = 12'hF13,
                          A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;  // RV32I
  localparam logic [31:0] MIE_MASK = 32'h0000_0880 |
                                     (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);

  function automatic logic csr_known(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH,
      A_MVENDOR, A_MARCHID, A_MIMPID, A_MHARTID: csr_known = 1'b1;
      default:                                   csr_known = 1'b0;
    endcase
  endfunction

  logic          st_mie, st_mpie;
  logic [31:0]   irq_enable, mtvec, mscratch, mepc, mcause, mtval;
  logic [CW-1:0] mcycle, minstret;
  logic [63:0]   cyc64, ins64;
  logic [31:0]   cyc_shadow, ins_shadow;
  logic          mtip, meip;
  logic [LW-1:0] loc_pend;
  logic [31:0]   mip_val, pend, rdata;
  logic [4:0]    code_n;
  logic          wr;

  // A trap squashes the CSR write of its own cycle; reads still complete.
  assign wr       = bus.write_enable & ~activate_exception;
  assign cyc64    = 64'(mcycle);
  assign ins64    = 64'(minstret);
  assign mepc_out = mepc;

  // Local lines: rising-edge capture; a set beats a clearing write or trap.
  if (NUM_LOCAL_IRQ > 0) begin : g_loc
    for (genvar i = 0; i < NUM_LOCAL_IRQ; i++) begin : g_line
      logic prev, pend_bit, clr;
      assign clr = (wr && bus.write_addr == A_MIP && !bus.write_data_in[16+i]) ||
                   (activate_exception && is_interrupt && exception_code == 5'(16 + i));
      assign loc_pend[i] = pend_bit;
      // Edge history and pending bit for line i.
      always_ff @(posedge clk) begin
        if (sync_reset) begin
          prev     <= 1'b0;
          pend_bit <= 1'b0;
        end else begin
          prev     <= local_irq[i];
          pend_bit <= (local_irq[i] & ~prev) | (pend_bit & ~clr);
        end
      end
    end
  end else begin : g_noloc
    assign loc_pend = '0;
  end

  // Assemble the architectural mip view.
  always_comb begin
    mip_val     = '0;
    mip_val[7]  = mtip;
    mip_val[11] = meip;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_val[16+i] = loc_pend[i];
  end

  // CSR read mux; values are pre-write since they come straight from state.
  always_comb begin
    rdata = '0;
    case (bus.read_addr)
      A_MSTATUS:   rdata = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
      A_MISA:      rdata = MISA_VAL;
      A_MIE:       rdata = irq_enable;
      A_MTVEC:     rdata = mtvec;
      A_MSCRATCH:  rdata = mscratch;
      A_MEPC:      rdata = mepc;
      A_MCAUSE:    rdata = mcause;
      A_MTVAL:     rdata = mtval;
      A_MIP:       rdata = mip_val;
      A_MCYCLE:    rdata = cyc64[31:0];
      A_MINSTRET:  rdata = ins64[31:0];
      A_MCYCLEH:   rdata = cyc_shadow;
      A_MINSTRETH: rdata = ins_shadow;
      A_MHARTID:   rdata = HART_ID;
      default:     rdata = '0;
    endcase
  end

  // Read port, upper-half shadows and illegal-access pulse.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      bus.read_en_out   <= 1'b0;
      bus.read_data_out <= '0;
      cyc_shadow        <= '0;
      ins_shadow        <= '0;
      illegal_csr       <= 1'b0;
    end else begin
      bus.read_en_out <= bus.read_enable;
      if (bus.read_enable) bus.read_data_out <= rdata;
      if (bus.read_enable && bus.read_addr == A_MCYCLE)   cyc_shadow <= cyc64[63:32];
      if (bus.read_enable && bus.read_addr == A_MINSTRET) ins_shadow <= ins64[63:32];
      illegal_csr <= (bus.read_enable  && !csr_known(bus.read_addr)) ||
                     (bus.write_enable && !csr_known(bus.write_addr));
    end
  end

  // Counters: a write to either half replaces that cycle's increment.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr && bus.write_addr == A_MCYCLE)       mcycle <= CW'({cyc64[63:32], bus.write_data_in});
      else if (wr && bus.write_addr == A_MCYCLEH) mcycle <= CW'({bus.write_data_in, cyc64[31:0]});
      else                                        mcycle <= mcycle + CW'(1);
      if (wr && bus.write_addr == A_MINSTRET)       minstret <= CW'({ins64[63:32], bus.write_data_in});
      else if (wr && bus.write_addr == A_MINSTRETH) minstret <= CW'({bus.write_data_in, ins64[31:0]});
      else if (exe_enable)                          minstret <= minstret + CW'(1);
    end
  end

  // mstatus stacking: trap beats mret, mret beats a software write.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
    end else if (activate_exception) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (csr_mret_active) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr && bus.write_addr == A_MSTATUS) begin
      st_mie  <= bus.write_data_in[3];
      st_mpie <= bus.write_data_in[7];
    end
  end

  // Remaining read/write CSRs and trap capture.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      irq_enable <= '0;
      mtvec      <= '0;
      mscratch   <= '0;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
    end else begin
      if (wr && bus.write_addr == A_MIE)      irq_enable <= bus.write_data_in & MIE_MASK;
      if (wr && bus.write_addr == A_MSCRATCH) mscratch   <= bus.write_data_in;
`ifdef CSR_VECTORED_MTVEC_EN
      if (wr && bus.write_addr == A_MTVEC)
        mtvec <= {bus.write_data_in[31:2], 1'b0, bus.write_data_in[1:0] == 2'b01};
`else
      if (wr && bus.write_addr == A_MTVEC)
        mtvec <= {bus.write_data_in[31:2], 2'b00};
`endif
      if (activate_exception) begin
        mcause <= {is_interrupt, 26'd0, exception_code};
        mepc   <= exception_PC;
        mtval  <= exception_addr;
      end else begin
        if (wr && bus.write_addr == A_MEPC)   mepc   <= {bus.write_data_in[31:2], 2'b00};
        if (wr && bus.write_addr == A_MCAUSE) mcause <= bus.write_data_in;
        if (wr && bus.write_addr == A_MTVAL)  mtval  <= bus.write_data_in;
      end
    end
  end

`ifdef CSR_VECTORED_MTVEC_EN
  assign trap_target = (is_interrupt && mtvec[0])
                     ? {mtvec[31:2], 2'b00} + {25'd0, exception_code, 2'b00}
                     : {mtvec[31:2], 2'b00};
`else
  assign trap_target = {mtvec[31:2], 2'b00};
`endif

  // Fixed priority: MEI, then lowest local line, then MTI.
  always_comb begin
    code_n = 5'd0;
    if (pend[7]) code_n = 5'd7;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
      if (pend[16+i]) code_n = 5'(16 + i);
    if (pend[11]) code_n = 5'd11;
  end

  // Registered pending set and request; a trap cycle forces the request low.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      mtip     <= 1'b0;
      meip     <= 1'b0;
      pend     <= '0;
      irq_req  <= 1'b0;
      irq_code <= '0;
    end else begin
      mtip     <= timer_triggered;
      meip     <= ext_int_triggered;
      pend     <= mip_val & irq_enable;
      irq_req  <= !activate_exception && st_mie && (|pend);
      irq_code <= (!activate_exception && st_mie && (|pend)) ? code_n : 5'd0;
    end
  end
endmodule

// File: tb/tb_reindeer_csr_irq.sv
// Directed bench for reindeer_csr_irq (default parameters).
module tb_reindeer_csr_irq;
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                          A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MCAUSE = 12'h342,
                          A_MTVAL = 12'h343, A_MIP = 12'h344, A_MCYCLE = 12'hB00,
                          A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80, A_MHARTID = 12'hF14;

  logic        clk = 1'b0;
  logic        sync_reset = 1'b1, exe_enable = 1'b0;
  logic        timer_triggered = 1'b0, ext_int_triggered = 1'b0;
  logic [3:0]  local_irq = '0;
  logic        csr_mret_active = 1'b0, activate_exception = 1'b0, is_interrupt = 1'b0;
  logic [4:0]  exception_code = '0;
  logic [31:0] exception_PC = '0, exception_addr = '0;
  logic        irq_req, illegal_csr;
  logic [4:0]  irq_code;
  logic [31:0] trap_target, mepc_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;
  logic        rd_en;

  reindeer_csr_irq_if bus();

  reindeer_csr_irq #(.NUM_LOCAL_IRQ(4), .COUNTER_WIDTH(64), .HART_ID(32'h0)) dut (
    .clk(clk), .sync_reset(sync_reset), .exe_enable(exe_enable), .bus(bus),
    .timer_triggered(timer_triggered), .ext_int_triggered(ext_int_triggered),
    .local_irq(local_irq), .csr_mret_active(csr_mret_active),
    .activate_exception(activate_exception), .is_interrupt(is_interrupt),
    .exception_code(exception_code), .exception_PC(exception_PC),
    .exception_addr(exception_addr), .irq_req(irq_req), .irq_code(irq_code),
    .trap_target(trap_target), .mepc_out(mepc_out), .illegal_csr(illegal_csr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
    bus.write_enable = 1'b1; bus.write_addr = a; bus.write_data_in = v;
    tick();
    bus.write_enable = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] v);
    bus.read_enable = 1'b1; bus.read_addr = a;
    tick();
    v = bus.read_data_out; rd_en = bus.read_en_out;
    bus.read_enable = 1'b0;
  endtask

  task automatic test_reset();
    sync_reset = 1'b1; tick(); tick(); sync_reset = 1'b0;
    csr_write(A_MCYCLE, 32'h123);
    csr_write(A_MSTATUS, 32'h8);
    csr_write(A_MIE, 32'h880);
    tick();
    sync_reset = 1'b1; tick(); sync_reset = 1'b0;
    checks++; if (bus.read_en_out !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %0b exp 0", bus.read_en_out); end
    checks++; if (bus.read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.read_data_out); end
    checks++; if (irq_req !== 1'b0 || irq_code !== 5'd0) begin errors++; $display("FAIL reset_irq got %0b/%0d exp 0/0", irq_req, irq_code); end
    csr_read(A_MCYCLE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mcycle got %h exp 0", d); end
    csr_read(A_MCYCLEH, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mcycleh got %h exp 0", d); end
    csr_read(A_MSTATUS, d);
    checks++; if (d !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h exp 00001800", d); end
    csr_read(A_MIE, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mie got %h exp 0", d); end
  endtask

  task automatic test_counter_wrap();
    csr_write(A_MCYCLE, 32'hFFFF_FFFF);
    csr_write(A_MCYCLEH, 32'h0);
    tick(); tick();
    csr_read(A_MCYCLE, d);
    checks++; if (d !== 32'h1 || rd_en !== 1'b1) begin errors++; $display("FAIL wrap_mcycle got %h en %0b exp 00000001 en 1", d, rd_en); end
    tick();
    checks++; if (bus.read_en_out !== 1'b0 || bus.read_data_out !== 32'h1) begin errors++; $display("FAIL read_hold got %h en %0b exp 00000001 en 0", bus.read_data_out, bus.read_en_out); end
    csr_read(A_MCYCLEH, d);
    checks++; if (d !== 32'h1 || rd_en !== 1'b1) begin errors++; $display("FAIL wrap_mcycleh got %h en %0b exp 00000001 en 1", d, rd_en); end
  endtask

  task automatic test_minstret();
    csr_write(A_MINSTRET, 32'h0);
    exe_enable = 1'b1; tick(); tick(); tick(); exe_enable = 1'b0;
    csr_read(A_MINSTRET, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL minstret got %h exp 00000003", d); end
  endtask

  task automatic test_priority();
    csr_write(A_MIE, 32'h10880);
    csr_write(A_MSTATUS, 32'h8);
    local_irq = 4'b0001; timer_triggered = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_code !== 5'd16) begin errors++; $display("FAIL prio_local got %0b/%0d exp 1/16", irq_req, irq_code); end
    ext_int_triggered = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (irq_req !== 1'b1 || irq_code !== 5'd11) begin errors++; $display("FAIL prio_ext got %0b/%0d exp 1/11", irq_req, irq_code); end
  endtask

  task automatic test_trap_stacking();
    exception_PC = 32'h0000_1234; exception_addr = 32'hDEAD_BEEF;
    is_interrupt = 1'b1; exception_code = 5'd16; activate_exception = 1'b1;
    tick();
    activate_exception = 1'b0; is_interrupt = 1'b0; exception_code = 5'd0;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL trap_irq_drop got %0b exp 0", irq_req); end
    checks++; if (mepc_out !== 32'h1234) begin errors++; $display("FAIL trap_mepc got %h exp 00001234", mepc_out); end
    csr_read(A_MSTATUS, d);
    checks++; if (d !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got %h exp 00001880", d); end
    csr_read(A_MIP, d);
    checks++; if (d !== 32'h880) begin errors++; $display("FAIL trap_mip got %h exp 00000880", d); end
    csr_read(A_MCAUSE, d);
    checks++; if (d !== 32'h8000_0010) begin errors++; $display("FAIL trap_mcause got %h exp 80000010", d); end
    csr_read(A_MTVAL, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL trap_mtval got %h exp deadbeef", d); end
    csr_mret_active = 1'b1; tick(); csr_mret_active = 1'b0;
    csr_read(A_MSTATUS, d);
    checks++; if (d !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp 00001888", d); end
    local_irq = '0; timer_triggered = 1'b0; ext_int_triggered = 1'b0;
    tick(); tick();
  endtask

  task automatic test_mtvec();
    logic [31:0] exp_tgt, exp_vec;
`ifdef CSR_VECTORED_MTVEC_EN
    exp_tgt = 32'h8000_011C; exp_vec = 32'h8000_0101;
`else
    exp_tgt = 32'h8000_0100; exp_vec = 32'h8000_0100;
`endif
    csr_write(A_MTVEC, 32'h8000_0101);
    is_interrupt = 1'b1; exception_code = 5'd7; #1;
    checks++; if (trap_target !== exp_tgt) begin errors++; $display("FAIL mtvec_target got %h exp %h", trap_target, exp_tgt); end
    is_interrupt = 1'b0; exception_code = 5'd0;
    csr_read(A_MTVEC, d);
    checks++; if (d !== exp_vec) begin errors++; $display("FAIL mtvec_read got %h exp %h", d, exp_vec); end
  endtask

  task automatic test_illegal();
    csr_read(12'h7C0, d);
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL illegal_read got %0b exp 1", illegal_csr); end
    tick();
    checks++; if (illegal_csr !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end got %0b exp 0", illegal_csr); end
    csr_write(A_MISA, 32'h0);
    checks++; if (illegal_csr !== 1'b0) begin errors++; $display("FAIL misa_write_pulse got %0b exp 0", illegal_csr); end
    csr_read(A_MISA, d);
    checks++; if (d !== 32'h4000_0100) begin errors++; $display("FAIL misa_value got %h exp 40000100", d); end
    csr_read(A_MHARTID, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mhartid got %h exp 0", d); end
    csr_write(12'h7C1, 32'h1);
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL illegal_write got %0b exp 1", illegal_csr); end
  endtask

  task automatic test_back_to_back();
    csr_write(A_MSCRATCH, 32'hA5A5_A5A5);
    bus.write_enable = 1'b1; bus.write_addr = A_MSCRATCH; bus.write_data_in = 32'h1234_5678;
    csr_read(A_MSCRATCH, d);
    bus.write_enable = 1'b0;
    checks++; if (d !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rw_prewrite got %h exp a5a5a5a5", d); end
    csr_read(A_MSCRATCH, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL rw_postwrite got %h exp 12345678", d); end
    activate_exception = 1'b1; exception_code = 5'd2;
    bus.write_enable = 1'b1; bus.write_addr = A_MSCRATCH; bus.write_data_in = 32'h5555_5555;
    csr_read(A_MSCRATCH, d);
    bus.write_enable = 1'b0; activate_exception = 1'b0; exception_code = 5'd0;
    checks++; if (d !== 32'h1234_5678 || rd_en !== 1'b1) begin errors++; $display("FAIL trap_read got %h en %0b exp 12345678 en 1", d, rd_en); end
    csr_read(A_MSCRATCH, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL trap_blocks_write got %h exp 12345678", d); end
  endtask

  task automatic test_mip_clear();
    local_irq[1] = 1'b1; tick();
    csr_read(A_MIP, d);
    checks++; if ((d & 32'h20000) !== 32'h20000) begin errors++; $display("FAIL mip_set got %h exp 00020000", d & 32'h20000); end
    csr_write(A_MIP, 32'h0);
    csr_read(A_MIP, d);
    checks++; if ((d & 32'h20000) !== 32'h0) begin errors++; $display("FAIL mip_clear got %h exp 0", d & 32'h20000); end
    local_irq[1] = 1'b0; tick();
    local_irq[1] = 1'b1;
    csr_write(A_MIP, 32'h0);
    csr_read(A_MIP, d);
    checks++; if ((d & 32'h20000) !== 32'h20000) begin errors++; $display("FAIL mip_set_wins got %h exp 00020000", d & 32'h20000); end
  endtask

  initial begin
    bus.read_enable = 1'b0; bus.read_addr = '0;
    bus.write_enable = 1'b0; bus.write_addr = '0; bus.write_data_in = '0;
    test_reset();
    test_counter_wrap();
    test_minstret();
    test_priority();
    test_trap_stacking();
    test_mtvec();
    test_illegal();
    test_back_to_back();
    test_mip_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reindeer_csr_irq.md
Name: reindeer_csr_irq

Overview:
Parametrised machine-mode CSR unit for the Reindeer core. It extends the M-mode CSR set with a configurable bank of local interrupt lines and configurable-width cycle/instret counters. It adds full MIE/MPIE trap and mret stacking, and it registers and prioritises the interrupt request presented to the pipeline. The unit sits beside the execute stage; the pipeline issues CSR read/write, trap and mret events to it.

Parameters:
NUM_LOCAL_IRQ, 4, number of local interrupt lines, 0..16; line i maps to mip/mie bit 16+i
COUNTER_WIDTH, 64, width of mcycle/minstret, 32..64; bits above COUNTER_WIDTH read as 0
HART_ID, 0, value returned by mhartid

Ports:
clk  in  1  clock
sync_reset  in  1  synchronous reset, active-high
exe_enable  in  1  one instruction retires this cycle
read_enable  in  1  CSR read request
read_addr  in  12  CSR read address
read_en_out  out  1  read data valid, one cycle after read_enable
read_data_out  out  32  read data
write_enable  in  1  CSR write request
write_addr  in  12  CSR write address
write_data_in  in  32  CSR write data
timer_triggered  in  1  machine timer level
ext_int_triggered  in  1  machine external interrupt level
local_irq  in  NUM_LOCAL_IRQ  local interrupt lines, edge-sensitive
csr_mret_active  in  1  mret retiring
activate_exception  in  1  trap taken this cycle
is_interrupt  in  1  trap is an interrupt
exception_code  in  5  cause code
exception_PC  in  32  PC to save in mepc
exception_addr  in  32  value to save in mtval
irq_req  out  1  enabled interrupt pending and mstatus.MIE=1
irq_code  out  5  cause code of the highest-priority pending interrupt
trap_target  out  32  handler address for the current trap
mepc_out  out  32  mepc
illegal_csr  out  1  one-cycle pulse on access to an unimplemented CSR

Behaviour:
- Reset: all CSRs, outputs and pendings = 0; mstatus.MIE=0, MPIE=0; edge-detect history = 0.
- Reset is synchronous and active-high; it has priority over every event.
- Read latency: 1 cycle.
- read_en_out = read_enable delayed 1 cycle; read_data_out holds its value when no read is issued.
- Read and write in the same cycle: both are performed. The read returns the pre-write value.
- activate_exception blocks that cycle's CSR write; the read still completes.
- mcycle increments every cycle. minstret increments when exe_enable=1.
- Reading mcycle/minstret latches the upper half into a shadow register; mcycleh/minstreth return the shadow.
- Writing mcycle/mcycleh/minstret/minstreth loads that half. The write overrides the increment in the same cycle.
- Counters wrap modulo 2^COUNTER_WIDTH.
- Trap (activate_exception=1): mcause={is_interrupt,26'd0,exception_code}; mepc=exception_PC; mtval=exception_addr; MPIE<=MIE; MIE<=0.
- On an interrupt trap with code 16+i, the local pending bit i clears.
- mret (csr_mret_active=1, no trap): MIE<=MPIE; MPIE<=1. A trap in the same cycle wins.
- mstatus read value: MIE bit3, MPIE bit7, MPP bits12:11 fixed at 2'b11.
- mip.MTIP (bit 7): timer_triggered registered 1 cycle; read-only.
- mip.MEIP (bit 11): ext_int_triggered registered 1 cycle; read-only.
- mip bit 16+i: set on a rising edge of local_irq[i]; writing 0 clears it; writing 1 is ignored.
- If a rising edge and a clearing write land in the same cycle, the set wins.
- mie: bits 7, 11 and 16..16+NUM_LOCAL_IRQ-1 are writable; all other bits read 0.
- Writes to misa, mvendorid, marchid, mimpid and mhartid are ignored without fault.
- Any other unimplemented address, on read or write, pulses illegal_csr for 1 cycle.
- pend = mip & mie, registered.
- irq_req = MIE & |pend, registered; it is 0 in the cycle after a trap.
- Priority: MEI (code 11) > local lowest index (16+i) > MTI (7).
- irq_code is valid only while irq_req=1; otherwise it is 0.

Optional Feature:
CSR_VECTORED_MTVEC_EN:
- Defined: mtvec[1:0] is writable, values 0 or 1 (2,3 store 0). For an interrupt trap with mtvec[1:0]=1, trap_target = {mtvec[31:2],2'b00} + 4*exception_code; otherwise trap_target = base.
- Undefined: mtvec[1:0] always reads 0 and trap_target = {mtvec[31:2],2'b00}.

Test Plan:
- Reset: assert sync_reset mid-count with mcycle=0x123 -> next cycle all reads return 0, irq_req=0.
- Counter wrap: COUNTER_WIDTH=64, write mcycle=0xFFFFFFFF and mcycleh=0, read mcycle then mcycleh -> 0x00000001 then 0x00000001; read_en_out 1 cycle after each read.
- Interrupt priority: mie=0x10880, MIE=1; raise local_irq[0] and timer together -> irq_req=1, irq_code=16. Add ext_int -> irq_code=11.
- Trap stacking: MIE=1, trap with code 16 -> MIE=0, MPIE=1, mip bit16=0, mcause=0x80000010. Then mret -> MIE=1, MPIE=1.
- Vectored mtvec (CSR_VECTORED_MTVEC_EN defined): mtvec=0x80000101, interrupt code 7 -> trap_target=0x8000011C. Without the macro -> 0x80000100.
- Illegal access: read 0x7C0 -> illegal_csr 1-cycle pulse. Write misa -> no pulse, value unchanged.
